// File: rtl/svm_ctrl_pkg.sv
// Shared types for the multiclass SVM controller: one-hot states,
// registered control bundle, width helper and default sizes.
package svm_ctrl_pkg;

   localparam int DEF_NUM_CLASSES = 4;
   localparam int DEF_NUM_BATCHES = 2;
   localparam int DEF_SU_CYCLES   = 4;

   localparam int NUM_STATES = 10;

   localparam int S_IDLE     = 0;
   localparam int S_ARM      = 1;
   localparam int S_VU_START = 2;
   localparam int S_VU_RUN   = 3;
   localparam int S_VU_DRAIN = 4;
   localparam int S_XFER     = 5;
   localparam int S_SU_RUN   = 6;
   localparam int S_SU_WAIT  = 7;
   localparam int S_BIAS     = 8;
   localparam int S_DONE     = 9;

   typedef enum logic [NUM_STATES-1:0] {
      ST_IDLE     = 10'(1 << S_IDLE),
      ST_ARM      = 10'(1 << S_ARM),
      ST_VU_START = 10'(1 << S_VU_START),
      ST_VU_RUN   = 10'(1 << S_VU_RUN),
      ST_VU_DRAIN = 10'(1 << S_VU_DRAIN),
      ST_XFER     = 10'(1 << S_XFER),
      ST_SU_RUN   = 10'(1 << S_SU_RUN),
      ST_SU_WAIT  = 10'(1 << S_SU_WAIT),
      ST_BIAS     = 10'(1 << S_BIAS),
      ST_DONE     = 10'(1 << S_DONE)
   } state_t;

   typedef struct packed {
      logic resetVU;
      logic resetSU;
      logic enableVU;
      logic enableSU;
      logic transfer;
      logic enableMems;
      logic addressEnable;
      logic enableAlphaU;
      logic enableAlphaMem;
      logic addBias;
      logic busy;
      logic done;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      resetVU: 1'b1,
      resetSU: 1'b1,
      default: 1'b0
   };

   // Ceiling log2, never below 1 so index ports stay legal.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/svm_su_timer.sv
// Down-counter pacing the scalar-unit phase; expires on the
// final SU cycle after a load.
module svm_su_timer #(
   parameter int CYCLES = 4,
   parameter int WIDTH  = 3
) (
   input  logic clock,
   input  logic userReset,
   input  logic load,
   input  logic decrement,
   output logic expire
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clock or posedge userReset) begin
      if (userReset) begin
         count <= '0;
      end else if (load) begin
         count <= WIDTH'(CYCLES - 1);
      end else if (decrement && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expire = (count == '0);

endmodule

// File: rtl/svm_multiclass_controller.sv
// Batch/class sequencer for the SVM datapath with start/busy/done
// handshake; outputs registered from the next-state decode.
module svm_multiclass_controller
   import svm_ctrl_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int NUM_BATCHES = DEF_NUM_BATCHES,
   parameter int SU_CYCLES   = DEF_SU_CYCLES,
   parameter int CLASS_W     = log2(NUM_CLASSES),
   parameter int BATCH_W     = log2(NUM_BATCHES)
) (
   input  logic               clock,
   input  logic               userReset,
   input  logic               start,
   input  logic               dataValid,
   input  logic               lastElement,
   input  logic               lastEnabled,
   input  logic               lastScalar,
   output logic               resetVU,
   output logic               resetSU,
   output logic               enableVU,
   output logic               enableSU,
   output logic               transfer,
   output logic               enableMems,
   output logic               AddressEnable,
   output logic               enableAlphaU,
   output logic               enableAlphaMem,
   output logic               addBias,
   output logic [CLASS_W-1:0] classIndex,
   output logic [BATCH_W-1:0] batchIndex,
   output logic               busy,
   output logic               done
);

   localparam int TIMER_W = log2(SU_CYCLES) + 1;

   logic [1:0]         rstPipe;
   logic               coreReset;
   state_t             state;
   state_t             stateNext;
   ctrl_t              ctrl;
   ctrl_t              ctrlNext;
   logic [CLASS_W-1:0] classNext;
   logic [BATCH_W-1:0] batchNext;
   logic               timerLoad;
   logic               timerDec;
   logic               timerExpire;
   logic               lastBatch;
   logic               lastClass;

   // Assert immediately, release two edges after userReset drops.
   always_ff @(posedge clock or posedge userReset) begin
      if (userReset) rstPipe <= 2'b11;
      else           rstPipe <= {rstPipe[0], 1'b0};
   end

   assign coreReset = rstPipe[1];

   svm_su_timer #(
      .CYCLES(SU_CYCLES),
      .WIDTH (TIMER_W)
   ) suTimer (
      .clock    (clock),
      .userReset(coreReset),
      .load     (timerLoad),
      .decrement(timerDec),
      .expire   (timerExpire)
   );

   assign lastBatch = int'(batchIndex) >= NUM_BATCHES - 1;
   assign lastClass = int'(classIndex) >= NUM_CLASSES - 1;

   always_comb begin
      stateNext = state;
      classNext = classIndex;
      batchNext = batchIndex;
      timerLoad = 1'b0;
      timerDec  = 1'b0;
      unique case (1'b1)
         state[S_IDLE]: begin
            if (start) begin
               stateNext = ST_ARM;
               classNext = '0;
               batchNext = '0;
            end
         end
         state[S_ARM]: begin
            if (dataValid) stateNext = ST_VU_START;
         end
         state[S_VU_START]: stateNext = ST_VU_RUN;
         state[S_VU_RUN]: begin
            if (lastElement) stateNext = ST_VU_DRAIN;
         end
         state[S_VU_DRAIN]: begin
            if (lastEnabled) stateNext = ST_XFER;
         end
         state[S_XFER]: begin
            stateNext = ST_SU_RUN;
            timerLoad = 1'b1;
         end
         state[S_SU_RUN]: begin
            if (timerExpire) stateNext = ST_SU_WAIT;
            else             timerDec  = 1'b1;
         end
         state[S_SU_WAIT]: begin
            if (lastScalar) begin
               if (lastBatch) begin
                  stateNext = ST_BIAS;
               end else begin
                  stateNext = ST_ARM;
                  batchNext = batchIndex + BATCH_W'(1);
               end
            end
         end
         state[S_BIAS]: begin
            if (lastClass) begin
               stateNext = ST_DONE;
            end else begin
               stateNext = ST_ARM;
               classNext = classIndex + CLASS_W'(1);
               batchNext = '0;
            end
         end
         state[S_DONE]: stateNext = ST_IDLE;
         default: begin
            stateNext = ST_IDLE;
            classNext = '0;
            batchNext = '0;
         end
      endcase
   end

   always_comb begin
      ctrlNext      = '0;
      ctrlNext.busy = 1'b1;
      unique case (1'b1)
         stateNext[S_IDLE]: ctrlNext = CTRL_IDLE;
         stateNext[S_ARM]:  ctrlNext.resetVU = 1'b1;
         stateNext[S_VU_START]: begin
            ctrlNext.enableMems    = 1'b1;
            ctrlNext.addressEnable = 1'b1;
            ctrlNext.enableVU      = 1'b1;
            ctrlNext.resetSU       = (batchNext == '0);
         end
         stateNext[S_VU_RUN]: begin
            ctrlNext.enableMems    = 1'b1;
            ctrlNext.addressEnable = 1'b1;
            ctrlNext.enableVU      = 1'b1;
         end
         stateNext[S_VU_DRAIN]: ;
         stateNext[S_XFER]: begin
            ctrlNext.transfer     = 1'b1;
            ctrlNext.enableAlphaU = 1'b1;
         end
         stateNext[S_SU_RUN]: begin
            ctrlNext.enableSU = 1'b1;
            if (!state[S_SU_RUN]) begin
               ctrlNext.enableAlphaMem = 1'b1;
               ctrlNext.enableAlphaU   = 1'b1;
            end
         end
         stateNext[S_SU_WAIT]: ;
         stateNext[S_BIAS]: ctrlNext.addBias = 1'b1;
         stateNext[S_DONE]: ctrlNext.done    = 1'b1;
         default: ctrlNext = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge coreReset) begin
      if (coreReset) begin
         state      <= ST_IDLE;
         ctrl       <= CTRL_IDLE;
         classIndex <= '0;
         batchIndex <= '0;
      end else begin
         state      <= stateNext;
         ctrl       <= ctrlNext;
         classIndex <= classNext;
         batchIndex <= batchNext;
      end
   end

   assign resetVU        = ctrl.resetVU;
   assign resetSU        = ctrl.resetSU;
   assign enableVU       = ctrl.enableVU;
   assign enableSU       = ctrl.enableSU;
   assign transfer       = ctrl.transfer;
   assign enableMems     = ctrl.enableMems;
   assign AddressEnable  = ctrl.addressEnable;
   assign enableAlphaU   = ctrl.enableAlphaU;
   assign enableAlphaMem = ctrl.enableAlphaMem;
   assign addBias        = ctrl.addBias;
   assign busy           = ctrl.busy;
   assign done           = ctrl.done;

endmodule

// File: tb/tb_svm_multiclass_controller.sv
// Bench: expands a per-run plan of phases into an expected
// cycle trace and compares the controller against it.
module tb_svm_multiclass_controller;

   localparam int NC = 4;
   localparam int NB = 2;
   localparam int SC = 4;

   localparam int G_IDLE = 0;
   localparam int G_ARM  = 1;
   localparam int G_VS   = 2;
   localparam int G_VR   = 3;
   localparam int G_VD   = 4;
   localparam int G_X    = 5;
   localparam int G_SU   = 6;
   localparam int G_SW   = 7;
   localparam int G_BIAS = 8;
   localparam int G_DONE = 9;

   typedef struct {
      int seg;
      int c;
      int b;
      bit first;
      bit st;
      bit dv;
      bit le;
      bit ln;
      bit ls;
   } step_t;

   logic clock = 1'b0;
   logic userReset;
   logic start, dataValid, lastElement;
   logic lastEnabled, lastScalar;
   logic resetVU, resetSU, enableVU, enableSU;
   logic transfer, enableMems, AddressEnable;
   logic enableAlphaU, enableAlphaMem, addBias;
   logic [1:0] classIndex;
   logic [0:0] batchIndex;
   logic busy, done;

   logic start2, hs2;
   logic d2rVU, d2rSU, d2eVU, d2eSU, d2tr, d2mem;
   logic d2adr, d2aU, d2aM, d2bias, d2busy, d2done;
   logic [0:0] d2class, d2batch;

   logic [11:0] obs;

   step_t plan[$];
   int suMark;
   int prevC, prevB;
   int total = 0;
   int passed = 0;
   int cntTransfer, cntBias, cntDone, cntRsu, cntSu;

   always #5 clock = ~clock;

   svm_multiclass_controller dut (
      .clock(clock), .userReset(userReset),
      .start(start), .dataValid(dataValid),
      .lastElement(lastElement),
      .lastEnabled(lastEnabled),
      .lastScalar(lastScalar),
      .resetVU(resetVU), .resetSU(resetSU),
      .enableVU(enableVU), .enableSU(enableSU),
      .transfer(transfer), .enableMems(enableMems),
      .AddressEnable(AddressEnable),
      .enableAlphaU(enableAlphaU),
      .enableAlphaMem(enableAlphaMem),
      .addBias(addBias), .classIndex(classIndex),
      .batchIndex(batchIndex), .busy(busy),
      .done(done)
   );

   svm_multiclass_controller #(
      .NUM_CLASSES(1), .NUM_BATCHES(1), .SU_CYCLES(2)
   ) dut2 (
      .clock(clock), .userReset(userReset),
      .start(start2), .dataValid(hs2),
      .lastElement(hs2), .lastEnabled(hs2),
      .lastScalar(hs2),
      .resetVU(d2rVU), .resetSU(d2rSU),
      .enableVU(d2eVU), .enableSU(d2eSU),
      .transfer(d2tr), .enableMems(d2mem),
      .AddressEnable(d2adr), .enableAlphaU(d2aU),
      .enableAlphaMem(d2aM), .addBias(d2bias),
      .classIndex(d2class), .batchIndex(d2batch),
      .busy(d2busy), .done(d2done)
   );

   assign obs = {resetVU, resetSU, enableVU, enableSU,
                 transfer, enableMems, AddressEnable,
                 enableAlphaU, enableAlphaMem, addBias,
                 busy, done};

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s: got %0h want %0h",
                  tag, got, want);
   endtask

   // Control values each phase must show, in obs bit order.
   function automatic logic [11:0] expCtrl(step_t s);
      logic rVU, rSU, eVU, eSU, tr, mem, aU, aM, bi, bz, dn;
      rVU = 0; rSU = 0; eVU = 0; eSU = 0; tr = 0;
      mem = 0; aU = 0; aM = 0; bi = 0; dn = 0; bz = 1;
      case (s.seg)
         G_IDLE: begin rVU = 1; rSU = 1; bz = 0; end
         G_ARM:  rVU = 1;
         G_VS:   begin mem = 1; eVU = 1; rSU = (s.b == 0); end
         G_VR:   begin mem = 1; eVU = 1; end
         G_X:    begin tr = 1; aU = 1; end
         G_SU:   begin eSU = 1; aU = s.first; aM = s.first; end
         G_BIAS: bi = 1;
         G_DONE: dn = 1;
         default: ;
      endcase
      return {rVU, rSU, eVU, eSU, tr, mem, mem,
              aU, aM, bi, bz, dn};
   endfunction

   function automatic int pick(input int d);
      return (d < 0) ? int'($urandom_range(4, 0)) : d;
   endfunction

   // Random noise on every input, then the sampled one forced.
   task automatic addSeg(input int seg, input int c,
                         input int b, input bit first,
                         input bit sv);
      step_t s;
      s.seg = seg; s.c = c; s.b = b; s.first = first;
      s.st = 1'($urandom); s.dv = 1'($urandom);
      s.le = 1'($urandom); s.ln = 1'($urandom);
      s.ls = 1'($urandom);
      case (seg)
         G_IDLE: s.st = sv;
         G_ARM:  s.dv = sv;
         G_VR:   s.le = sv;
         G_VD:   s.ln = sv;
         G_SW:   s.ls = sv;
         default: ;
      endcase
      plan.push_back(s);
   endtask

   task automatic addWait(input int seg, input int c,
                          input int b, input int d);
      repeat (d) addSeg(seg, c, b, 0, 0);
      addSeg(seg, c, b, 0, 1);
   endtask

   task automatic buildRun(input int dvD, input int leD,
                           input int lnD, input int lsD);
      plan.delete();
      suMark = -1;
      addSeg(G_IDLE, prevC, prevB, 0, 0);
      addSeg(G_IDLE, prevC, prevB, 0, 0);
      addSeg(G_IDLE, prevC, prevB, 0, 1);
      for (int c = 0; c < NC; c++) begin
         for (int b = 0; b < NB; b++) begin
            addWait(G_ARM, c, b, pick(dvD));
            addSeg(G_VS, c, b, 0, 0);
            addWait(G_VR, c, b, pick(leD));
            addWait(G_VD, c, b, pick(lnD));
            addSeg(G_X, c, b, 0, 0);
            for (int k = 0; k < SC; k++) begin
               if (c == 2 && b == 0 && k == 1)
                  suMark = plan.size();
               addSeg(G_SU, c, b, k == 0, 0);
            end
            addWait(G_SW, c, b, pick(lsD));
         end
         addSeg(G_BIAS, c, NB - 1, 0, 0);
      end
      addSeg(G_DONE, NC - 1, NB - 1, 0, 0);
      prevC = NC - 1;
      prevB = NB - 1;
   endtask

   task automatic driveIdle();
      start = 0; dataValid = 0; lastElement = 0;
      lastEnabled = 0; lastScalar = 0;
   endtask

   task automatic checkReset(input string tag);
      check({tag, " ctrl"}, 32'(obs), 32'hC00);
      check({tag, " class"}, 32'(classIndex), 0);
      check({tag, " batch"}, 32'(batchIndex), 0);
   endtask

   task automatic runPlan(input bit doAbort);
      step_t s;
      cntTransfer = 0; cntBias = 0; cntDone = 0;
      cntRsu = 0; cntSu = 0;
      for (int i = 0; i < plan.size(); i++) begin
         s = plan[i];
         @(negedge clock);
         check($sformatf("ctrl@%0d seg%0d", i, s.seg),
               32'(obs), 32'(expCtrl(s)));
         check($sformatf("class@%0d", i),
               32'(classIndex), s.c);
         check($sformatf("batch@%0d", i),
               32'(batchIndex), s.b);
         cntTransfer += int'(transfer);
         cntBias     += int'(addBias);
         cntDone     += int'(done);
         cntSu       += int'(enableSU);
         cntRsu      += int'(resetSU && busy);
         if (doAbort && i == suMark) begin
            driveIdle();
            #2 userReset = 1;
            #1 checkReset("async reset");
            @(negedge clock);
            userReset = 0;
            repeat (3) @(negedge clock);
            prevC = 0;
            prevB = 0;
            return;
         end
         start       = s.st;
         dataValid   = s.dv;
         lastElement = s.le;
         lastEnabled = s.ln;
         lastScalar  = s.ls;
      end
   endtask

   initial begin
      int edges;
      bit seen;
      driveIdle();
      start2 = 0;
      hs2 = 1;
      userReset = 1;
      prevC = 0;
      prevB = 0;
      repeat (3) @(negedge clock);
      checkReset("power-on");
      userReset = 0;
      repeat (3) @(negedge clock);

      buildRun(0, 0, 0, 0);
      runPlan(0);
      check("transfer pulses", cntTransfer, NC * NB);
      check("addBias pulses", cntBias, NC);
      check("done pulses", cntDone, 1);
      check("resetSU pulses", cntRsu, NC);
      check("enableSU cycles", cntSu, NC * NB * SC);

      buildRun(7, 0, 3, 0);
      runPlan(0);
      check("stall transfer", cntTransfer, NC * NB);

      buildRun(-1, -1, -1, -1);
      runPlan(1);

      buildRun(-1, -1, -1, -1);
      runPlan(0);
      check("post-reset done", cntDone, 1);

      buildRun(-1, -1, -1, -1);
      runPlan(0);

      @(negedge clock);
      start2 = 1;
      @(posedge clock);
      #1 start2 = 0;
      edges = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clock);
         #1 edges++;
         seen = d2bias;
      end
      check("single bias seen", 32'(seen), 1);
      check("single bias latency", edges, 8);
      @(posedge clock);
      #1 check("single done", 32'(d2done), 1);
      check("single bias once", 32'(d2bias), 0);
      check("single class", 32'(d2class), 0);
      @(posedge clock);
      #1 check("single busy off", 32'(d2busy), 0);
      check("single done off", 32'(d2done), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/svm_multiclass_controller.md
# svm_multiclass_controller

Parametrised successor of the single-pass SVM controller: sequences the vector units (VU), the alpha unit and memories, and the scalar units (SU) over multiple support-vector batches and multiple one-vs-rest classes. It has a start/busy/done handshake and restarts without a reset. It sits between the frame/window fetch logic, which drives `dataValid`, and the SVM datapath (VU array, alpha memory, SU chain, bias adder).

## Interface
Parameters:
- `NUM_CLASSES`, 4: one-vs-rest classifiers evaluated per window; ≥1.
- `NUM_BATCHES`, 2: support-vector batches per class; ≥1.
- `SU_CYCLES`, 4: cycles `enableSU` is held per batch (maxColumn equivalent); ≥2.
- `CLASS_W`, log2(NUM_CLASSES) min 1: width of `classIndex`.
- `BATCH_W`, log2(NUM_BATCHES) min 1: width of `batchIndex`.

Ports:
- `clock`  in  1  sole clock; rising edge.
- `userReset`  in  1  Asynchronous active-high reset.
- `start`  in  1  Begin a window classification; sampled only in IDLE.
- `dataValid`  in  1  Window data ready; sampled only in ARM.
- `lastElement`  in  1  Final vector element fetched; sampled only in VU_RUN.
- `lastEnabled`  in  1  Last VU drained; sampled only in VU_DRAIN.
- `lastScalar`  in  1  SU chain result settled; sampled only in SU_WAIT.
- `resetVU`, `resetSU`, `enableVU`, `enableSU`, `transfer`, `enableMems`, `AddressEnable`, `enableAlphaU`, `enableAlphaMem`, `addBias`  out  1 each  Datapath controls.
- `classIndex`  out  CLASS_W  Class being evaluated.
- `batchIndex`  out  BATCH_W  Batch being evaluated.
- `busy`  out  1  High from leaving IDLE until return to IDLE.
- `done`  out  1  One-cycle pulse after final class bias.

## Operation
- All outputs are registered. Each state's output values are present for the whole time the FSM is in that state.
- Reset values: state IDLE, `resetVU`=1, `resetSU`=1, all other 1-bit outputs 0, indices 0.
- IDLE: `resetVU`=`resetSU`=1. On `start`: clear both indices, go to ARM.
- ARM: `resetVU`=1, `busy`=1. On `dataValid`, go to VU_START.
- VU_START (1 cycle): `enableMems`=`AddressEnable`=`enableVU`=1. `resetSU`=1 only when `batchIndex`==0, so SU accumulation carries across batches of one class. Next state is VU_RUN.
- VU_RUN: `enableMems`=`AddressEnable`=`enableVU`=1. On `lastElement`, go to VU_DRAIN.
- VU_DRAIN: all enables 0. On `lastEnabled`, go to XFER.
- XFER (1 cycle): `transfer`=1, `enableAlphaU`=1. Next state is SU_RUN.
- SU_RUN (exactly SU_CYCLES cycles): `enableSU`=1. `enableAlphaMem`=1 on the first cycle only. `enableAlphaU`=1 on the first cycle only. Then go to SU_WAIT.
- SU_WAIT: `enableSU`=0. On `lastScalar`:
  - if `batchIndex`<NUM_BATCHES-1: `batchIndex`++, go to ARM;
  - otherwise go to BIAS.
- BIAS (1 cycle): `addBias`=1. Then:
  - if `classIndex`<NUM_CLASSES-1: `classIndex`++, `batchIndex`=0, go to ARM;
  - otherwise go to DONE.
- DONE (1 cycle): `done`=1, `busy`=1. Next state is IDLE; `classIndex` holds its last value until the next `start`.
- Boundaries:
  - An input is ignored outside its sampling state; this includes `start` while busy.
  - `lastElement` in VU_START is ignored. VU_RUN is always at least 1 cycle.
  - With NUM_CLASSES=1 and NUM_BATCHES=1, the only path is IDLE→…→BIAS→DONE.
  - Index increments saturate by construction; an index never wraps mid-run.
  - `userReset` mid-operation: outputs and state return to reset values asynchronously. Deassertion is synchronised; the first active edge finds the FSM in IDLE.
  - Illegal or unencoded state → IDLE with reset output values.

## Timing
- `start` to `busy`: 1 cycle.
- ARM→VU_START: 1 cycle after `dataValid` is sampled.
- XFER to first `enableSU`: 1 cycle.
- SU_RUN length is exactly SU_CYCLES, counted by the internal timer, independent of inputs.
- Minimum cycles per batch with all handshakes immediate: 1 (ARM) + 1 + 1 + 1 + 1 + SU_CYCLES + 1 = SU_CYCLES+6. BIAS adds 1 per class.
- `done` rises exactly 1 cycle after the final `addBias`. `busy` falls on the cycle after `done`.

## Structure
- Shared package `svm_ctrl_pkg`: one-hot state encoding (10 states), the `log2` function, and the default parameter constants.
- One sub-module, `svm_su_timer`: a loadable down-counter of width log2(SU_CYCLES)+1. It is loaded in XFER and asserts `expire` on the last SU_RUN cycle. It is reset by the same async `userReset`.

## Test plan
- Defaults, immediate handshakes:
  - `start`, then `dataValid`/`lastElement`/`lastEnabled`/`lastScalar` each asserted on the first cycle they are sampled.
  - Required: 8 `transfer` pulses, 4 `addBias` pulses with `classIndex` 0,1,2,3, and `done` 1 cycle after the 4th `addBias`.
  - Required: each batch is 10 cycles and `enableSU` is high for exactly 4 cycles each time.
- Accumulator clearing: `resetSU` pulses only in VU_START with `batchIndex`=0 (4 pulses per run). It is never asserted between batch 0 and batch 1 of a class.
- Stalls: delay `dataValid` by 7 cycles and `lastEnabled` by 3 cycles. Required: the FSM holds ARM/VU_DRAIN with outputs stable and no missed or extra pulses.
- Ignored inputs:
  - `start` asserted while busy: no effect.
  - `lastScalar` asserted during SU_RUN: SU_RUN still lasts 4 cycles.
  - `lastElement` asserted in VU_START: not taken.
- Async reset: assert `userReset` mid-SU_RUN of class 2 between clock edges. Required: immediately `enableSU`=0, `resetVU`=`resetSU`=1, indices 0, `busy`=0. The next `start` runs a full clean classification.
- NUM_CLASSES=1, NUM_BATCHES=1, SU_CYCLES=2: a single pass ending in one `addBias` and one `done`, 8 cycles after `start`.
